// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: queued colour commands ramp three duty registers that drive glitch-free PWM outputs.
module rgb_fade_sequencer #(
  parameter int DUTY_W = 16,
  parameter int DIV_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_red,
  input  logic [DUTY_W-1:0] cmd_green,
  input  logic [DUTY_W-1:0] cmd_blue,
  input  logic [DUTY_W-1:0] cmd_rate,
  input  logic [DIV_W-1:0]  tick_div,
  input  logic              abort,
  output logic              pwm_red,
  output logic              pwm_green,
  output logic              pwm_blue,
  output logic              busy,
  output logic              fade_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 4 * DUTY_W;
  typedef enum logic [1:0] {IDLE, LOAD, FADE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, tick, all_done;
  logic [DUTY_W-1:0] cnt, rate;
  logic [DUTY_W-1:0] duty_red, duty_green, duty_blue;
  logic [DUTY_W-1:0] shadow_red, shadow_green, shadow_blue;
  logic [DUTY_W-1:0] target_red, target_green, target_blue;
  logic [DUTY_W-1:0] next_red, next_green, next_blue;
  logic [DIV_W-1:0] presc;

  // Move cur toward tgt by min(r, |tgt-cur|) using one extra bit so nothing wraps.
  function automatic logic [DUTY_W-1:0] step_to(input logic [DUTY_W-1:0] cur, tgt, r);
    logic up;
    logic [DUTY_W:0] d, s;
    up = tgt >= cur;
    d = up ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
    s = ({1'b0, r} < d) ? {1'b0, r} : d;
    return up ? DUTY_W'({1'b0, cur} + s) : DUTY_W'({1'b0, cur} - s);
  endfunction

  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push = cmd_valid && !full && !abort;
  assign pop = (state == IDLE) && !empty && !abort;
  assign tick = (state == FADE) && (presc == tick_div);
  assign busy = (state != IDLE) || !empty;
  assign next_red = step_to(duty_red, target_red, rate);
  assign next_green = step_to(duty_green, target_green, rate);
  assign next_blue = step_to(duty_blue, target_blue, rate);
  assign all_done = (next_red == target_red) && (next_green == target_green) && (next_blue == target_blue);

  always_comb begin
    state_nx = abort ? IDLE
             : state == IDLE ? (empty ? IDLE : LOAD)
             : state == LOAD ? (rate == '0 ? IDLE : FADE)
             : (state == FADE && !(tick && all_done)) ? FADE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_red, cmd_green, cmd_blue, cmd_rate};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      {shadow_red, shadow_green, shadow_blue} <= '0;
      {duty_red, duty_green, duty_blue} <= '0;
      {target_red, target_green, target_blue, rate} <= '0;
      {pwm_red, pwm_green, pwm_blue, fade_done} <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      presc <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) {shadow_red, shadow_green, shadow_blue} <= {duty_red, duty_green, duty_blue};
      pwm_red <= cnt < shadow_red;
      pwm_green <= cnt < shadow_green;
      pwm_blue <= cnt < shadow_blue;
      fade_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (abort) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) {target_red, target_green, target_blue, rate} <= mem[rd_ptr[AW-1:0]];
      presc <= (state == FADE && !tick) ? presc + 1'b1 : '0;
      if (!abort && state == LOAD && rate == '0) begin
        {duty_red, duty_green, duty_blue} <= {target_red, target_green, target_blue};
        fade_done <= 1'b1;
      end
      if (!abort && tick) begin
        {duty_red, duty_green, duty_blue} <= {next_red, next_green, next_blue};
        fade_done <= all_done;
      end
    end
  end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed scoreboard bench for the fade sequencer with an 8-bit duty width.
module tb_rgb_fade_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic cmd_ready, pwm_red, pwm_green, pwm_blue, busy, fade_done;
  logic [7:0] cmd_red = '0, cmd_green = '0, cmd_blue = '0, cmd_rate = '0, tick_div = '0;
  int passed = 0, total = 0, done_cnt = 0;
  logic [23:0] done_q[$];
  logic [7:0] step_q[$];

  rgb_fade_sequencer #(.DUTY_W(8), .DIV_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue), .cmd_rate(cmd_rate),
    .tick_div(tick_div), .abort(abort), .pwm_red(pwm_red), .pwm_green(pwm_green),
    .pwm_blue(pwm_blue), .busy(busy), .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; score any fade step and any fade_done against the queues.
  task automatic cyc();
    logic t;
    t = dut.tick;
    @(posedge clk);
    #1;
    if (t && step_q.size() > 0) chk("fade_step", dut.duty_red, step_q.pop_front());
    if (fade_done) begin
      done_cnt++;
      if (done_q.size() > 0) chk("done_duty", {dut.duty_red, dut.duty_green, dut.duty_blue}, done_q.pop_front());
      else chk("done_unexpected", done_q.size(), 1);
    end
  endtask

  task automatic send(input logic [7:0] r, g, b, rt);
    int n = 0;
    {cmd_red, cmd_green, cmd_blue, cmd_rate} = {r, g, b, rt};
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      cyc();
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output int n);
    n = 0;
    while (done_cnt < target && n < 500) begin
      cyc();
      n++;
    end
    chk("done_timeout", done_cnt >= target, 1);
  endtask

  initial begin
    int n, base, r, g, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {busy, fade_done, pwm_red, pwm_green, pwm_blue}, 0);
    rst_n = 1'b1;
    cyc();
    chk("cnt_start", dut.cnt, 1);

    done_q.push_back({8'h80, 8'h00, 8'hFF});
    send(8'h80, 8'h00, 8'hFF, 8'h00);
    cyc();
    chk("jump_early", fade_done, 0);
    cyc();
    chk("jump_lat", fade_done, 1);
    cyc();
    chk("jump_pulse", fade_done, 0);
    repeat (260) cyc();
    r = 0; g = 0; b = 0;
    repeat (256) begin
      cyc();
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
    end
    chk("pwm_red_half", r, 128);
    chk("pwm_green_off", g, 0);
    chk("pwm_blue_full", b, 255);

    done_q.push_back(24'h0);
    send(8'h00, 8'h00, 8'h00, 8'h00);
    wait_done(done_cnt + 1, n);
    tick_div = 8'd3;
    step_q = {8'd30, 8'd60, 8'd90, 8'd100};
    done_q.push_back({8'd100, 8'd0, 8'd0});
    send(8'd100, 8'd0, 8'd0, 8'd30);
    wait_done(done_cnt + 1, n);
    chk("up_latency", n, 18);
    chk("up_steps_left", step_q.size(), 0);

    step_q = {8'd60, 8'd20, 8'd5};
    done_q.push_back({8'd5, 8'd0, 8'd0});
    base = done_cnt;
    send(8'd5, 8'd0, 8'd0, 8'd40);
    wait_done(base + 1, n);
    chk("down_latency", n, 14);
    cyc();
    chk("down_once", done_cnt, base + 1);

    base = done_cnt;
    done_q.push_back({8'd200, 8'd0, 8'd0});
    done_q.push_back({8'd1, 8'd2, 8'd3});
    done_q.push_back({8'd4, 8'd5, 8'd6});
    done_q.push_back({8'd7, 8'd8, 8'd9});
    done_q.push_back({8'd10, 8'd20, 8'd30});
    done_q.push_back({8'h10, 8'h10, 8'h10});
    send(8'd200, 8'd0, 8'd0, 8'd10);
    send(8'd1, 8'd2, 8'd3, 8'd0);
    send(8'd4, 8'd5, 8'd6, 8'd0);
    send(8'd7, 8'd8, 8'd9, 8'd0);
    send(8'd10, 8'd20, 8'd30, 8'd0);
    chk("fifo_full", cmd_ready, 0);
    chk("fifo_busy", busy, 1);
    send(8'h10, 8'h10, 8'h10, 8'h00);
    wait_done(base + 6, n);
    chk("burst_count", done_cnt, base + 6);
    chk("burst_queue", done_q.size(), 0);
    chk("burst_idle", busy, 0);

    base = done_cnt;
    send(8'h90, 8'h10, 8'h10, 8'h08);
    send(8'h55, 8'h55, 8'h55, 8'h00);
    send(8'h66, 8'h66, 8'h66, 8'h00);
    repeat (10) cyc();
    {cmd_red, cmd_green, cmd_blue, cmd_rate} = {8'h77, 8'h77, 8'h77, 8'h00};
    cmd_valid = 1'b1;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_freeze", {dut.duty_red, dut.duty_green, dut.duty_blue}, {8'h20, 8'h10, 8'h10});
    repeat (20) cyc();
    chk("abort_no_done", done_cnt, base);
    chk("abort_flushed", busy, 0);
    step_q = {8'h30};
    done_q.push_back({8'h30, 8'h10, 8'h10});
    send(8'h30, 8'h10, 8'h10, 8'h10);
    wait_done(base + 1, n);
    chk("resume_latency", n, 6);

    send(8'hF0, 8'hF0, 8'hF0, 8'h01);
    repeat (30) cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_outs", {pwm_red, pwm_green, pwm_blue, fade_done, busy}, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_cnt", dut.cnt, 0);
    chk("arst_duty", {dut.duty_red, dut.duty_green, dut.duty_blue}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("arst_cnt_restart", dut.cnt, 1);
    chk("arst_ready_after", cmd_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
